// File: rtl/comb_filter_bank_pkg.sv
// Shared types and helpers for the time-multiplexed comb filter bank.
// Fixed-point position and delay depth default here unless the build overrides them.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 16
`endif

package comb_filter_bank_pkg;

  localparam int FP       = `FIXED_POINT;
  localparam int SAMPLE_W = 24;
  localparam int WORD_W   = SAMPLE_W + FP;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic {
    COMB_FB = 1'b0,
    COMB_FF = 1'b1
  } comb_mode_e;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD,
    ST_MUL,
    ST_ACC,
    ST_DONE
  } state_e;

  // a + b clipped to the signed range of a w-bit word; operands arrive sign-extended
  function automatic logic signed [127:0] sat_add(input logic signed [127:0] a,
                                                  input logic signed [127:0] b,
                                                  input int                  w);
    logic signed [127:0] s, hi, lo;
    s  = a + b;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/comb_filter_bank_ram.sv
// Simple dual-port delay store: one write port, one registered read port, no reset.
module comb_filter_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // read data holds between reads so the datapath can use it for several cycles
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/comb_filter_bank.sv
// Bank of comb filters sharing one delay RAM; channels processed serially, 3 cycles each.
// Feedback mode outputs the delayed word and stores x+g*d; feedforward outputs x+g*d and stores x.
module comb_filter_bank
  import comb_filter_bank_pkg::*;
#(
  parameter  int WIDTH    = SAMPLE_W,
  parameter  int MAXLEN   = `MAX_FILTER_FIFO_LENGTH,
  parameter  int CHANNELS = 4,
  localparam int WORD     = WIDTH + FP,
  localparam int TW       = $clog2(MAXLEN),
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            sample_clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  output logic                            ready,
  input  logic [CHANNELS-1:0][WORD-1:0]   in,
  input  logic [CHANNELS-1:0][TW-1:0]     tau,
  input  logic [CHANNELS-1:0][WORD-1:0]   gain,
  input  logic [CHANNELS-1:0]             mode,
  output logic [CHANNELS-1:0][WORD-1:0]   out,
  output logic                            out_valid,
  output logic                            overrun
);

  localparam int PW = 2 * WORD;
  localparam int AW = CW + TW;

  state_e                         state_q, state_d;
  logic [AW-1:0]                  clr_q, clr_d;
  logic [CW-1:0]                  ch_q, ch_d;
  logic [CHANNELS-1:0][TW-1:0]    wp_q;
  logic [CHANNELS-1:0][WORD-1:0]  x_q, g_q, out_q;
  logic [CHANNELS-1:0][TW-1:0]    tau_q;
  logic [CHANNELS-1:0]            mode_q;
  logic signed [PW-1:0]           prod_q;
  logic                           ov_q;

  logic                           ram_we, ram_re;
  logic [AW-1:0]                  ram_waddr, ram_raddr;
  logic [WORD-1:0]                ram_wdata, ram_rdata;

  logic [TW-1:0]                  tau_eff, rd_off;
  logic signed [WORD-1:0]         d_s, g_s, x_s, sum;
  logic signed [PW-1:0]           g_ext, d_ext, prod_d, shifted;
  logic                           last_ch, is_ff;

  comb_filter_bank_ram #(
    .DW (WORD),
    .AW (AW)
  ) u_ram (
    .clk_i   (sample_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // tau=0 would read the slot being written this frame, so it is treated as 1
  always_comb begin
    tau_eff = (tau_q[ch_q] == '0) ? TW'(1) : tau_q[ch_q];
    rd_off  = wp_q[ch_q] - tau_eff;
    last_ch = (ch_q == CW'(CHANNELS - 1));
    is_ff   = (comb_mode_e'(mode_q[ch_q]) == COMB_FF);
  end

  always_comb begin
    d_s     = ram_rdata;
    g_s     = g_q[ch_q];
    x_s     = x_q[ch_q];
    g_ext   = PW'(g_s);
    d_ext   = PW'(d_s);
    prod_d  = g_ext * d_ext;
    shifted = prod_q >>> FP;
    sum     = WORD'(sat_add(128'(x_s), 128'(shifted), WORD));
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    ch_d      = ch_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = {ch_q, rd_off};
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        clr_d     = clr_q + AW'(1);
        if (&clr_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid) begin
          ch_d    = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ram_re  = 1'b1;
        state_d = ST_MUL;
      end
      ST_MUL: state_d = ST_ACC;
      ST_ACC: begin
        ram_we    = 1'b1;
        ram_waddr = {ch_q, wp_q[ch_q]};
        ram_wdata = is_ff ? x_s : sum;
        if (last_ch) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      ch_q    <= '0;
      wp_q    <= '0;
      x_q     <= '0;
      g_q     <= '0;
      tau_q   <= '0;
      mode_q  <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ch_q    <= ch_d;
      ov_q    <= in_valid & ~ready;
      if (state_q == ST_IDLE && in_valid) begin
        x_q    <= in;
        g_q    <= gain;
        tau_q  <= tau;
        mode_q <= mode;
      end
      if (state_q == ST_MUL) prod_q <= prod_d;
      if (state_q == ST_ACC) begin
        wp_q[ch_q]  <= wp_q[ch_q] + TW'(1);
        out_q[ch_q] <= is_ff ? sum : d_s;
      end
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign overrun   = ov_q;
  assign out       = out_q;

endmodule

// File: tb/tb_comb_filter_bank.sv
// Self-checking bench for comb_filter_bank: directed impulse cases plus randomized frames
// against a frame-indexed history model of each channel.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 16
`endif

module tb_comb_filter_bank;
  import comb_filter_bank_pkg::*;

  localparam int     CH   = 4;
  localparam int     ML   = `MAX_FILTER_FIFO_LENGTH;
  localparam int     W    = SAMPLE_W + FP;
  localparam int     TW   = $clog2(ML);
  localparam int     LAT  = 3 * CH + 1;
  localparam int     MAXF = 512;
  localparam longint U    = 64'sd1 <<< FP;
  localparam longint WMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint WMIN = -WMAX - 64'sd1;

  logic                      sample_clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      ready, out_valid, overrun;
  logic [CH-1:0][W-1:0]      in_x = '0, gain_x = '0, out_x;
  logic [CH-1:0][TW-1:0]     tau_x = '0;
  logic [CH-1:0]             mode_x = '0;

  int checks = 0;
  int errors = 0;

  // history of stored words per channel, indexed by frame number since last reset
  longint hist [CH][MAXF];
  int     nf = 0;

  comb_filter_bank dut (
    .sample_clk (sample_clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .ready      (ready),
    .in         (in_x),
    .tau        (tau_x),
    .gain       (gain_x),
    .mode       (mode_x),
    .out        (out_x),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  always #5 sample_clk = ~sample_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] wv(input longint v);
    return v[W-1:0];
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint clip(input longint v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_gain();
    longint v;
    v = longint'($urandom_range(4 * U)) - 2 * U;
    return wv(v);
  endfunction

  task automatic model_frame(input logic [CH-1:0][W-1:0] x, input logic [CH-1:0][W-1:0] g,
                             input logic [CH-1:0][TW-1:0] t, input logic [CH-1:0] m,
                             output logic [CH-1:0][W-1:0] e);
    for (int c = 0; c < CH; c++) begin
      longint xv, gv, d, s;
      int te;
      xv = sx(x[c]);
      gv = sx(g[c]);
      te = (t[c] == '0) ? 1 : int'(t[c]);
      d  = (nf - te >= 0) ? hist[c][nf - te] : 0;
      s  = clip(xv + ((gv * d) >>> FP));
      if (m[c]) begin
        e[c] = wv(s);
        hist[c][nf] = xv;
      end else begin
        e[c] = wv(d);
        hist[c][nf] = s;
      end
    end
    nf++;
  endtask

  task automatic scramble();
    for (int c = 0; c < CH; c++) begin
      in_x[c]   = $urandom();
      gain_x[c] = $urandom();
      tau_x[c]  = TW'($urandom());
    end
    mode_x = CH'($urandom());
  endtask

  task automatic apply_reset();
    int k = 0;
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge sample_clk); #1;
    rstn = 1'b1;
    while (!ready && k < 4 * CH * ML) begin @(posedge sample_clk); #1; k++; end
    nf = 0;
  endtask

  // drives one frame, scrambles the inputs while it is in flight and returns what came out
  task automatic run_frame(input logic [CH-1:0][W-1:0] x, input logic [CH-1:0][W-1:0] g,
                           input logic [CH-1:0][TW-1:0] t, input logic [CH-1:0] m,
                           input int glitch_at, output logic [CH-1:0][W-1:0] got,
                           output int lat, output int ov_cnt, output int ov_at);
    int k = 0;
    got = '0;
    while (!ready && k < 400) begin @(posedge sample_clk); #1; k++; end
    in_x = x; gain_x = g; tau_x = t; mode_x = m;
    in_valid = 1'b1;
    @(posedge sample_clk); #1;
    in_valid = 1'b0;
    lat = -1; ov_cnt = 0; ov_at = -1;
    for (int c = 1; c <= LAT + 4; c++) begin
      if (overrun) begin ov_cnt++; ov_at = c; end
      if (out_valid) begin lat = c; got = out_x; break; end
      scramble();
      in_valid = (c == glitch_at);
      @(posedge sample_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    int k, lat, oc, oa;
    rstn = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge sample_clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (out_x !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out_x); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    rstn = 1'b1;
    k = 0;
    while (!ready && k < 4 * CH * ML) begin @(posedge sample_clk); #1; k++; end
    checks++; if (k != CH * ML) begin errors++; $display("FAIL clear_length got %0d exp %0d", k, CH * ML); end
    nf = 0;
    for (int f = 0; f < 3; f++) begin
      x = '0;
      for (int c = 0; c < CH; c++) begin g[c] = rnd_gain(); t[c] = TW'($urandom()); end
      run_frame(x, g, t, CH'($urandom()), -1, got, lat, oc, oa);
      model_frame(x, g, t, '0, e);
      checks++; if (got !== '0) begin errors++; $display("FAIL cleared_out f%0d got %h exp 0", f, got); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL cleared_lat f%0d got %0d exp %0d", f, lat, LAT); end
    end
  endtask

  task automatic test_fb_impulse();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    longint ev;
    int lat, oc, oa;
    apply_reset();
    for (int f = 0; f < 12; f++) begin
      x = '0; g = '0;
      x[0] = (f == 0) ? wv(U) : '0;
      g[0] = wv(U / 2);
      for (int c = 0; c < CH; c++) t[c] = TW'($urandom());
      t[0] = TW'(3);
      m = CH'($urandom()); m[0] = 1'b0;
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      ev = (f == 3) ? U : (f == 6) ? U / 2 : (f == 9) ? U / 4 : 0;
      checks++; if (got[0] !== wv(ev)) begin errors++; $display("FAIL fb_ch0 f%0d got %0d exp %0d", f, sx(got[0]), ev); end
      checks++; if (got !== e) begin errors++; $display("FAIL fb_model f%0d got %h exp %h", f, got, e); end
    end
  endtask

  task automatic test_ff_impulse();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    longint ev;
    int lat, oc, oa;
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      x = '0; g = '0; t = '0; m = '0;
      x[1] = (f == 0) ? wv(U) : '0;
      g[1] = wv(-U / 2);
      t[1] = TW'(2);
      m[1] = 1'b1;
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      ev = (f == 0) ? U : (f == 2) ? -U / 2 : 0;
      checks++; if (got[1] !== wv(ev)) begin errors++; $display("FAIL ff_ch1 f%0d got %0d exp %0d", f, sx(got[1]), ev); end
      checks++; if (got !== e) begin errors++; $display("FAIL ff_model f%0d got %h exp %h", f, got, e); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL ff_latency f%0d got %0d exp %0d", f, lat, LAT); end
    end
  endtask

  task automatic test_saturation();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    int lat, oc, oa;
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      x = '0; g = '0; t = '0; m = '0;
      x[2] = wv(WMAX); g[2] = wv(U); t[2] = TW'(1);
      x[3] = wv(WMIN); g[3] = wv(U); t[3] = TW'(1); m[3] = 1'b1;
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      checks++; if (got !== e) begin errors++; $display("FAIL sat_model f%0d got %h exp %h", f, got, e); end
      checks++; if (got[2][W-1] !== 1'b0) begin errors++; $display("FAIL sat_sign f%0d got %0d exp >=0", f, sx(got[2])); end
    end
    checks++; if (got[2] !== wv(WMAX)) begin errors++; $display("FAIL sat_pos got %0d exp %0d", sx(got[2]), WMAX); end
    checks++; if (got[3] !== wv(WMIN)) begin errors++; $display("FAIL sat_neg got %0d exp %0d", sx(got[3]), WMIN); end
  endtask

  task automatic test_tau0();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    longint ev;
    int lat, oc, oa;
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      x = '0; g = '0; t = '0; m = '0;
      x[3] = (f == 0) ? wv(U) : '0;
      g[3] = wv(U); m[3] = 1'b1;
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      ev = (f <= 1) ? U : 0;
      checks++; if (got[3] !== wv(ev)) begin errors++; $display("FAIL tau0_ch3 f%0d got %0d exp %0d", f, sx(got[3]), ev); end
      checks++; if (got !== e) begin errors++; $display("FAIL tau0_model f%0d got %h exp %h", f, got, e); end
    end
  endtask

  task automatic test_overrun();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    int lat, oc, oa;
    for (int c = 0; c < CH; c++) begin x[c] = $urandom(); g[c] = rnd_gain(); t[c] = TW'($urandom()); end
    m = CH'($urandom());
    run_frame(x, g, t, m, 5, got, lat, oc, oa);
    model_frame(x, g, t, m, e);
    checks++; if (oc != 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", oc); end
    checks++; if (oa != 6) begin errors++; $display("FAIL overrun_cycle got %0d exp 6", oa); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL overrun_latency got %0d exp %0d", lat, LAT); end
    checks++; if (got !== e) begin errors++; $display("FAIL overrun_out got %h exp %h", got, e); end
  endtask

  task automatic test_reset_midframe();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    int lat, oc, oa, k, seen;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < CH; c++) begin x[c] = $urandom(); g[c] = rnd_gain(); t[c] = TW'(1 + f); end
      run_frame(x, g, t, '0, -1, got, lat, oc, oa);
      model_frame(x, g, t, '0, e);
    end
    k = 0;
    while (!ready && k < 100) begin @(posedge sample_clk); #1; k++; end
    scramble();
    in_valid = 1'b1;
    @(posedge sample_clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge sample_clk);
    #1;
    rstn = 1'b0;
    @(posedge sample_clk); #1;
    rstn = 1'b1;
    k = 0; seen = 0;
    while (!ready && k < 4 * CH * ML) begin
      if (out_valid) seen++;
      @(posedge sample_clk); #1; k++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_out_valid got %0d exp 0", seen); end
    checks++; if (k != CH * ML) begin errors++; $display("FAIL abort_clear_length got %0d exp %0d", k, CH * ML); end
    nf = 0;
    for (int f = 0; f < 5; f++) begin
      x = '0;
      for (int c = 0; c < CH; c++) begin g[c] = rnd_gain(); t[c] = TW'($urandom()); end
      m = CH'($urandom());
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      checks++; if (got !== '0) begin errors++; $display("FAIL abort_rezeroed f%0d got %h exp 0", f, got); end
    end
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0][W-1:0]  x, g, got, e;
    logic [CH-1:0][TW-1:0] t;
    logic [CH-1:0]         m;
    int lat, oc, oa;
    apply_reset();
    for (int f = 0; f < 60; f++) begin
      for (int c = 0; c < CH; c++) begin
        x[c] = ($urandom_range(7) == 0) ? wv(($urandom_range(1) == 0) ? WMAX : WMIN) : W'($urandom());
        g[c] = rnd_gain();
        t[c] = TW'($urandom());
      end
      m = CH'($urandom());
      run_frame(x, g, t, m, -1, got, lat, oc, oa);
      model_frame(x, g, t, m, e);
      checks++; if (got !== e) begin errors++; $display("FAIL random_out f%0d got %h exp %h", f, got, e); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL random_latency f%0d got %0d exp %0d", f, lat, LAT); end
      @(posedge sample_clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready f%0d got %b exp 1", f, ready); end
    end
  endtask

  initial begin
    test_reset();
    test_fb_impulse();
    test_ff_impulse();
    test_saturation();
    test_tau0();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
